// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word request, programmable wait
// states, then a response held until the initiator takes it.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  LAT_W   = 4'(LATENCY);
    localparam logic        LAT_Z   = (LATENCY == 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [3:0]    cnt;
    logic          lat_wr;
    logic          lat_err;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;

    logic          req_err;
    logic          accept;
    logic          access;
    logic          done;
    logic          acc_wr;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;

    logic [31:0] mem [DEPTH];

    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH_W);

    // Zero-latency builds access straight off the request bus in IDLE.
    always_comb begin
        if (state == IDLE) begin
            acc_wr    = req_write;
            acc_err   = req_err;
            acc_idx   = req_addr[AW+1:2];
            acc_wdata = req_wdata;
        end else begin
            acc_wr    = lat_wr;
            acc_err   = lat_err;
            acc_idx   = lat_idx;
            acc_wdata = lat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        access    = 1'b0;
        done      = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LAT_Z) begin
                        access    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            lat_wr    <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= LAT_W;
                lat_wr    <= req_write;
                lat_err   <= req_err;
                lat_idx   <= req_addr[AW+1:2];
                lat_wdata <= req_wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_error <= acc_err;
                rsp_rdata <= (!acc_wr && !acc_err) ? mem[acc_idx] : 32'd0;
            end else if (done) begin
                rsp_error <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

    // Reset wins over a same-cycle access, so a store in flight is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && access && acc_wr && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 and a LATENCY=0 build
// share the clock and reset; expected responses queue at request time.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_error [2];

    typedef struct {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model [2][256];
    int          checks;
    int          errors;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u_lat2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_write (req_write[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_error (rsp_error[0])
    );

    dmem_responder #(.DEPTH(256), .LATENCY(0)) u_lat0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_write (req_write[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_error (rsp_error[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic noise(input int i);
        req_valid[i] = 1'($urandom);
        req_write[i] = 1'($urandom);
        req_addr[i]  = $urandom & 32'h0000_03fc;
        req_wdata[i] = $urandom;
    endtask

    task automatic check_idle(input int i, input string tag);
        check({tag, "_req_ready"}, 32'(req_ready[i]), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid[i]), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata[i], 32'd0);
        check({tag, "_rsp_error"}, 32'(rsp_error[i]), 32'd0);
    endtask

    // Starts and ends just after a falling edge.
    task automatic do_req(input int i, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int hold,
                          input logic nz);
        exp_t        e;
        exp_t        got;
        logic        err;
        logic [31:0] held;
        int          lat;
        err     = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        e.error = err;
        e.rdata = (!w && !err) ? model[i][a[9:2]] : 32'd0;
        exp_q.push_back(e);
        if (w && !err) model[i][a[9:2]] = d;
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        rsp_ready[i] = 1'b1;
        check("req_ready_idle", 32'(req_ready[i]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[i] = 1'b0;
        lat = 0;
        while (!rsp_valid[i] && lat < 40) begin
            if (nz) noise(i);
            check("req_ready_wait", 32'(req_ready[i]), 32'd0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        req_valid[i] = 1'b0;
        check("rsp_latency", 32'(lat), 32'(lat_of(i)));
        if (!rsp_valid[i]) begin
            void'(exp_q.pop_front());
            return;
        end
        got = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata[i], got.rdata);
        check("rsp_error", 32'(rsp_error[i]), 32'(got.error));
        held = rsp_rdata[i];
        if (hold > 0) rsp_ready[i] = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (nz) noise(i);
            @(posedge clk);
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid[i]), 32'd1);
            check("bp_rsp_rdata", rsp_rdata[i], held);
            check("bp_req_ready", 32'(req_ready[i]), 32'd0);
        end
        req_valid[i] = 1'b0;
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle(i, "post_hs");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            rsp_ready[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        check_idle(0, "rst0");
        check_idle(1, "rst1");
        rst_n = 1'b1;
        @(negedge clk);

        do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        do_req(0, 1'b1, 32'h08, 32'h1234_5678, 0, 1'b0);
        do_req(0, 1'b1, 32'h00, 32'hCAFE_F00D, 0, 1'b0);
        do_req(0, 1'b0, 32'h12, 32'h0, 0, 1'b0);
        do_req(0, 1'b1, 32'h400, 32'hBAD0_BAD0, 0, 1'b0);
        do_req(0, 1'b0, 32'h00, 32'h0, 0, 1'b0);
        do_req(0, 1'b0, 32'h3fc, 32'h0, 0, 1'b0);
        do_req(0, 1'b1, 32'h3fc, 32'h0F0F_0F0F, 0, 1'b0);
        do_req(0, 1'b0, 32'h3fc, 32'h0, 0, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, 5, 1'b0);
        do_req(0, 1'b1, 32'h20, 32'h55AA_33CC, 2, 1'b1);
        do_req(0, 1'b0, 32'h20, 32'h0, 3, 1'b1);

        // Store dropped by a reset pulse while waiting.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h08;
        req_wdata[0] = 32'hAAAA_5555;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(0, "rst_wait");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_rsp_after_rst", 32'(rsp_valid[0]), 32'd0);
        end
        do_req(0, 1'b0, 32'h08, 32'h0, 0, 1'b0);

        do_req(1, 1'b1, 32'h04, 32'h0000_0001, 0, 1'b0);
        do_req(1, 1'b0, 32'h04, 32'h0, 0, 1'b0);
        do_req(1, 1'b0, 32'h06, 32'h0, 0, 1'b0);
        do_req(1, 1'b1, 32'h1000, 32'h7777_7777, 0, 1'b0);
        do_req(1, 1'b0, 32'h04, 32'h0, 2, 1'b1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
